axis_ad5791_cfg_sequencer: RTL

//  Upstream companion of the AD5791 SPI driver. Runs one configuration frame on a start pulse.

---
 rtl/axis_ad5791_cfg_sequencer_if.sv | 30 +++
 rtl/axis_ad5791_cfg_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axis_ad5791_cfg_sequencer_if.sv
// Configuration-side link between the sequencer and the AD5791 SPI driver:
// mode/axis/send controls, the config AXIS word stream and the driver's ready flag.
interface axis_ad5791_cfg_sequencer_if #(
  parameter int SAXIS_TDATA_WIDTH = 32
);
  logic                         configuration_mode;
  logic [2:0]                   configuration_axis;
  logic                         configuration_send;
  logic [SAXIS_TDATA_WIDTH-1:0] M_AXISCFG_tdata;
  logic                         M_AXISCFG_tvalid;
  logic                         dac_ready;

  modport master (
    output configuration_mode,
    output configuration_axis,
    output configuration_send,
    output M_AXISCFG_tdata,
    output M_AXISCFG_tvalid,
    input  dac_ready
  );

  modport slave (
    input  configuration_mode,
    input  configuration_axis,
    input  configuration_send,
    input  M_AXISCFG_tdata,
    input  M_AXISCFG_tvalid,
    output dac_ready
  );
endinterface

// File: rtl/axis_ad5791_cfg_sequencer.sv
// Runs one AD5791 configuration frame per start pulse: loads a word per DAC into the
// driver, requests a send, tracks the driver's ready handshake and returns it to streaming.
module axis_ad5791_cfg_sequencer #(
  parameter int NUM_DAC           = 4,
  parameter int DAC_WORD_WIDTH    = 24,
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MODE_SETUP        = 4,
  parameter int SEND_HOLD         = 16,
  parameter int TIMEOUT           = 1024
) (
  input  logic                              a_clk,
  input  logic                              a_resetn,
  input  logic                              start,
  input  logic [NUM_DAC*DAC_WORD_WIDTH-1:0] cfg_words,
  axis_ad5791_cfg_sequencer_if.master       cfg,
  output logic                              busy,
  output logic                              done,
  output logic                              skipped,
  output logic                              fault
);

  localparam int CNT_MAX = (MODE_SETUP > SEND_HOLD) ?
                           ((MODE_SETUP > TIMEOUT) ? MODE_SETUP : TIMEOUT) :
                           ((SEND_HOLD > TIMEOUT) ? SEND_HOLD : TIMEOUT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DAC > 1) ? $clog2(NUM_DAC) : 1;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ENTER   = 4'd1;
  localparam logic [3:0] S_LOAD    = 4'd2;
  localparam logic [3:0] S_ARM     = 4'd3;
  localparam logic [3:0] S_SEND    = 4'd4;
  localparam logic [3:0] S_SHIFT   = 4'd5;
  localparam logic [3:0] S_RELEASE = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  logic [3:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      send_q, send_d;
  logic                      skipped_q, skipped_d;
  logic                      fault_q, fault_d;
  logic [1:0]                rdySync_q;
  logic [DAC_WORD_WIDTH-1:0] shadow_q [NUM_DAC];
  logic                      captureShadow;
  logic                      rdyS;

  // dac_ready comes from the driver's SPI clock domain, so resynchronise it
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      rdySync_q <= 2'b00;
    end else begin
      rdySync_q <= {rdySync_q[0], cfg.dac_ready};
    end
  end

  assign rdyS = rdySync_q[1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    send_d        = 1'b0;
    skipped_d     = skipped_q;
    fault_d       = fault_q;
    captureShadow = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          captureShadow = 1'b1;
          skipped_d     = 1'b0;
          fault_d       = 1'b0;
          cnt_d         = '0;
          state_d       = S_ENTER;
        end
      end
      S_ENTER: begin
        if (cnt_q == CNT_W'(MODE_SETUP - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (idx_q == IDX_W'(NUM_DAC - 1)) begin
          cnt_d   = '0;
          state_d = S_ARM;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_ARM: begin
        // Raise send on SEND entry only if the driver already reports ready
        if (cnt_q == CNT_W'(SEND_HOLD - 1)) begin
          cnt_d   = '0;
          send_d  = rdyS;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        send_d = send_q;
        cnt_d  = cnt_q + CNT_W'(1);
        if (send_q && !rdyS) begin
          send_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          send_d    = 1'b0;
          skipped_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_RELEASE;
        end else if (rdyS) begin
          send_d = 1'b1;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rdyS) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = S_ERR;
        end
      end
      S_RELEASE: begin
        if (cnt_q == CNT_W'(SEND_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      send_q    <= 1'b0;
      skipped_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      send_q    <= send_d;
      skipped_q <= skipped_d;
      fault_q   <= fault_d;
    end
  end

  // Later cfg_words changes must not disturb a frame already in flight
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      for (int i = 0; i < NUM_DAC; i++) shadow_q[i] <= '0;
    end else if (captureShadow) begin
      for (int i = 0; i < NUM_DAC; i++) begin
        shadow_q[i] <= cfg_words[i*DAC_WORD_WIDTH +: DAC_WORD_WIDTH];
      end
    end
  end

  assign cfg.configuration_mode = (state_q == S_ENTER) || (state_q == S_LOAD) ||
                                  (state_q == S_ARM)   || (state_q == S_SEND) ||
                                  (state_q == S_SHIFT) || (state_q == S_RELEASE);
  assign cfg.configuration_send = send_q;
  assign cfg.M_AXISCFG_tvalid   = (state_q == S_LOAD);
  assign cfg.configuration_axis = 3'(idx_q);
  assign cfg.M_AXISCFG_tdata    = SAXIS_TDATA_WIDTH'(shadow_q[idx_q]);

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign skipped = skipped_q;
  assign fault   = fault_q;

endmodule
